// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with byte/half/word access, sign/zero-extended loads,
// post-reset zero scrub, registered read data and alignment/range fault reporting.
`timescale 1ns/1ps

module data_memory_sized #(
    parameter int unsigned ADDR_BITS      = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        Ready,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Fault
);

    localparam int unsigned           DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0]  LAST_IDX  = ADDR_BITS'(DEPTH - 1);
    localparam logic [1:0]            SIZE_BYTE = 2'b00;
    localparam logic [1:0]            SIZE_HALF = 2'b01;
    localparam logic [1:0]            SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t                state;
    state_t                next_state;
    logic [ADDR_BITS-1:0]  clr_idx;
    logic [ADDR_BITS-1:0]  next_clr_idx;

    logic [31:0]           mem [DEPTH];

    logic [ADDR_BITS-1:0]  word_idx;
    logic [1:0]            lane;
    logic                  out_of_range_c;
    logic                  bad_c;
    logic                  fault_c;
    logic                  store_c;
    logic                  load_c;
    logic [3:0]            be_c;
    logic [31:0]           wdata_c;
    logic [31:0]           rword_c;
    logic [7:0]            rbyte_c;
    logic [15:0]           rhalf_c;
    logic [31:0]           load_data_c;

    assign word_idx = Address[ADDR_BITS+1:2];
    assign lane     = Address[1:0];

    // State register and scrub counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= RESET_STATE;
            clr_idx <= '0;
            Ready   <= (RESET_STATE == ST_RUN);
        end else begin
            state   <= next_state;
            clr_idx <= next_clr_idx;
            Ready   <= (next_state == ST_RUN);
        end
    end

    always_comb begin
        next_state   = state;
        next_clr_idx = clr_idx;
        case (state)
            ST_CLEAR: begin
                next_clr_idx = clr_idx + ADDR_BITS'(1);
                if (clr_idx == LAST_IDX) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN:  next_state = ST_RUN;
            default: next_state = RESET_STATE;
        endcase
    end

    // Request classification; faults listed in priority order
    assign out_of_range_c = (Address >> (ADDR_BITS + 32'd2)) != 32'd0;

    always_comb begin
        bad_c = 1'b0;
        if (MemRead && MemWrite) begin
            bad_c = 1'b1;
        end else if (MemSize == 2'b11) begin
            bad_c = 1'b1;
        end else if ((MemSize == SIZE_HALF) && Address[0]) begin
            bad_c = 1'b1;
        end else if ((MemSize == SIZE_WORD) && (lane != 2'b00)) begin
            bad_c = 1'b1;
        end else if (out_of_range_c) begin
            bad_c = 1'b1;
        end
    end

    assign fault_c = Ready && (MemRead || MemWrite) && bad_c;
    assign store_c = Ready && MemWrite && !bad_c;
    assign load_c  = Ready && MemRead && !bad_c;

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = WriteData;
        case (MemSize)
            SIZE_BYTE: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{WriteData[7:0]}};
            end
            SIZE_HALF: begin
                be_c    = Address[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteData[15:0]}};
            end
            SIZE_WORD: begin
                be_c    = 4'b1111;
                wdata_c = WriteData;
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = WriteData;
            end
        endcase
    end

    // Storage: scrub writes take over the port while clearing
    always_ff @(posedge Clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= 32'h0;
        end else if (store_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Lane select and extension for loads
    assign rword_c = mem[word_idx];
    assign rbyte_c = rword_c[{lane, 3'b000} +: 8];
    assign rhalf_c = rword_c[{Address[1], 4'b0000} +: 16];

    always_comb begin
        load_data_c = rword_c;
        case (MemSize)
            SIZE_BYTE: load_data_c = {{24{MemSigned & rbyte_c[7]}}, rbyte_c};
            SIZE_HALF: load_data_c = {{16{MemSigned & rhalf_c[15]}}, rhalf_c};
            default:   load_data_c = rword_c;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ReadData  <= 32'h0;
            ReadValid <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            ReadData  <= load_c ? load_data_c : 32'h0;
            ReadValid <= load_c;
            Fault     <= fault_c;
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: a 16-word instance for most scenarios,
// a 1024-word instance for range checks and a no-scrub instance for reset state.
`timescale 1ns/1ps

module tb_data_memory_sized;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n_b;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        mem_signed;

    logic        ready,   ready_b,   ready_c;
    logic [31:0] rdata,   rdata_b,   rdata_c;
    logic        rvalid,  rvalid_b,  rvalid_c;
    logic        fault,   fault_b,   fault_c;

    always #5 clk = ~clk;

    data_memory_sized #(.ADDR_BITS(4), .CLEAR_ON_RESET(1'b1)) dut (
        .Clk(clk), .Rst_n(rst_n), .Address(address), .WriteData(wdata),
        .MemWrite(mem_write), .MemRead(mem_read), .MemSize(mem_size), .MemSigned(mem_signed),
        .Ready(ready), .ReadData(rdata), .ReadValid(rvalid), .Fault(fault)
    );

    data_memory_sized #(.ADDR_BITS(10), .CLEAR_ON_RESET(1'b1)) dut_b (
        .Clk(clk), .Rst_n(rst_n_b), .Address(address), .WriteData(wdata),
        .MemWrite(mem_write), .MemRead(mem_read), .MemSize(mem_size), .MemSigned(mem_signed),
        .Ready(ready_b), .ReadData(rdata_b), .ReadValid(rvalid_b), .Fault(fault_b)
    );

    data_memory_sized #(.ADDR_BITS(4), .CLEAR_ON_RESET(1'b0)) dut_c (
        .Clk(clk), .Rst_n(rst_n), .Address(address), .WriteData(wdata),
        .MemWrite(mem_write), .MemRead(mem_read), .MemSize(mem_size), .MemSigned(mem_signed),
        .Ready(ready_c), .ReadData(rdata_c), .ReadValid(rvalid_c), .Fault(fault_c)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wd;
    } stim_t;

    stim_t       stim_q[$];
    logic [33:0] exp_q[$];
    string       name_q[$];
    logic [33:0] obs_q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic set_idle();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 32'h0;
        wdata      = 32'h0;
        mem_size   = 2'b10;
        mem_signed = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue one request and the {ReadValid, Fault, ReadData} it must produce
    task automatic push(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] wd, input logic exp_rv, input logic exp_flt,
                        input logic [31:0] exp_data);
        stim_t s;
        s.rd = rd; s.wr = wr; s.addr = addr; s.size = size; s.sgn = sgn; s.wd = wd;
        stim_q.push_back(s);
        exp_q.push_back({exp_rv, exp_flt, exp_data});
        name_q.push_back(name);
    endtask

    // One request per cycle, recording the outputs that follow each edge
    task automatic run();
        stim_t s;
        while (stim_q.size() > 0) begin
            s          = stim_q.pop_front();
            mem_read   = s.rd;
            mem_write  = s.wr;
            address    = s.addr;
            mem_size   = s.size;
            mem_signed = s.sgn;
            wdata      = s.wd;
            tick();
            obs_q.push_back({rvalid, fault, rdata});
        end
        set_idle();
    endtask

    task automatic count_to_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        set_idle();
        rst_n   = 1'b0;
        rst_n_b = 1'b0;
        tick();
        tick();
        n_total++;
        if ({ready, rvalid, fault, rdata} !== 35'h0) begin
            $display("FAIL reset_values: got ready=%b rv=%b flt=%b data=%h, want 0 0 0 00000000",
                     ready, rvalid, fault, rdata);
        end else n_pass++;
        n_total++;
        if ({ready_c, rvalid_c, fault_c} !== 3'b100) begin
            $display("FAIL reset_noclear: got ready=%b rv=%b flt=%b, want 1 0 0",
                     ready_c, rvalid_c, fault_c);
        end else n_pass++;
        rst_n   = 1'b1;
        rst_n_b = 1'b1;
        count_to_ready(n);
        n_total++;
        if (n !== 16) begin
            $display("FAIL clear_duration: got %0d edges, want 16", n);
        end else n_pass++;
    endtask

    task automatic test_scrub();
        int          n;
        logic        ign_err;
        logic [33:0] o;
        logic [33:0] e;
        string       nm;
        for (int i = 0; i < 16; i++) begin
            push("preload", 1'b0, 1'b1, 32'(i * 4), 2'b10, 1'b0, 32'hA5A5_0000 | 32'(i), 1'b0, 1'b0, 32'h0);
        end
        push("preload_rd", 1'b1, 1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5_000F);
        run();
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = obs_q.pop_front();
            n_total++;
            if (o !== e) begin
                $display("FAIL %s: got rv=%b flt=%b data=%h, want rv=%b flt=%b data=%h",
                         nm, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
            end else n_pass++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_total++;
        if (ready !== 1'b0) begin
            $display("FAIL ready_mid_scrub: got %b, want 0", ready);
        end else n_pass++;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        // Illegal request held through the scrub must be silently ignored
        mem_read  = 1'b1;
        mem_write = 1'b1;
        address   = 32'h3C;
        mem_size  = 2'b11;
        ign_err   = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (rvalid !== 1'b0 || fault !== 1'b0) ign_err = 1'b1;
        end
        set_idle();
        n_total++;
        if (n !== 16) begin
            $display("FAIL scrub_restart: got %0d edges, want 16", n);
        end else n_pass++;
        n_total++;
        if (ign_err !== 1'b0) begin
            $display("FAIL ignored_during_clear: got output activity %b, want 0", ign_err);
        end else n_pass++;
        push("scrub_3c", 1'b1, 1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        push("scrub_00", 1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        push("scrub_20", 1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        run();
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = obs_q.pop_front();
            n_total++;
            if (o !== e) begin
                $display("FAIL %s: got rv=%b flt=%b data=%h, want rv=%b flt=%b data=%h",
                         nm, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
            end else n_pass++;
        end
    endtask

    task automatic test_byte_half();
        logic [33:0] o;
        logic [33:0] e;
        string       nm;
        push("st_word",  1'b0, 1'b1, 32'h08, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
        push("st_byte",  1'b0, 1'b1, 32'h09, 2'b00, 1'b0, 32'h0000_00AA, 1'b0, 1'b0, 32'h0);
        push("st_half",  1'b0, 1'b1, 32'h0A, 2'b01, 1'b0, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0);
        push("ld_word8", 1'b1, 1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'hBEEF_AA44);
        push("ld_b9_s",  1'b1, 1'b0, 32'h09, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAA);
        push("ld_b9_u",  1'b1, 1'b0, 32'h09, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_00AA);
        push("ld_hA_s",  1'b1, 1'b0, 32'h0A, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_BEEF);
        push("ld_hA_u",  1'b1, 1'b0, 32'h0A, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_BEEF);
        push("ld_b8_s",  1'b1, 1'b0, 32'h08, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0044);
        push("ld_h8_s",  1'b1, 1'b0, 32'h08, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_AA44);
        push("ld_bB_u",  1'b1, 1'b0, 32'h0B, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_00BE);
        run();
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = obs_q.pop_front();
            n_total++;
            if (o !== e) begin
                $display("FAIL %s: got rv=%b flt=%b data=%h, want rv=%b flt=%b data=%h",
                         nm, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
            end else n_pass++;
        end
    endtask

    task automatic test_faults();
        int          n;
        logic [33:0] o;
        logic [33:0] e;
        string       nm;
        push("st_w0",      1'b0, 1'b1, 32'h00, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        push("f_half_odd", 1'b1, 1'b0, 32'h01, 2'b01, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        push("f_word_mis", 1'b1, 1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        push("f_size11",   1'b1, 1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        push("f_rd_wr",    1'b1, 1'b1, 32'h00, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        push("f_range_ld", 1'b1, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        push("f_half_st",  1'b0, 1'b1, 32'h01, 2'b01, 1'b0, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0);
        push("f_word_st",  1'b0, 1'b1, 32'h02, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        push("f_sz11_st",  1'b0, 1'b1, 32'h00, 2'b11, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        push("f_range_st", 1'b0, 1'b1, 32'h40, 2'b00, 1'b0, 32'h0000_00FF, 1'b0, 1'b1, 32'h0);
        push("w0_intact",  1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
        push("idle_after", 1'b0, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        run();
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = obs_q.pop_front();
            n_total++;
            if (o !== e) begin
                $display("FAIL %s: got rv=%b flt=%b data=%h, want rv=%b flt=%b data=%h",
                         nm, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
            end else n_pass++;
        end
        n = 0;
        while (ready_b !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        n_total++;
        if (ready_b !== 1'b1) begin
            $display("FAIL big_ready: got %b, want 1", ready_b);
        end else n_pass++;
        mem_read = 1'b1;
        address  = 32'h0000_1000;
        mem_size = 2'b10;
        tick();
        n_total++;
        if ({rvalid_b, fault_b, rdata_b} !== {1'b0, 1'b1, 32'h0}) begin
            $display("FAIL big_out_of_range: got rv=%b flt=%b data=%h, want rv=0 flt=1 data=00000000",
                     rvalid_b, fault_b, rdata_b);
        end else n_pass++;
        address = 32'h0000_0FFC;
        tick();
        set_idle();
        n_total++;
        if ({rvalid_b, fault_b, rdata_b} !== {1'b1, 1'b0, 32'h0}) begin
            $display("FAIL big_in_range: got rv=%b flt=%b data=%h, want rv=1 flt=0 data=00000000",
                     rvalid_b, fault_b, rdata_b);
        end else n_pass++;
    endtask

    task automatic test_pipelined();
        logic [33:0] o;
        logic [33:0] e;
        string       nm;
        for (int i = 0; i < 4; i++) begin
            push("pl_store", 1'b0, 1'b1, 32'(i * 4), 2'b10, 1'b0, 32'(i + 1), 1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            push("pl_load", 1'b1, 1'b0, 32'(i * 4), 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'(i + 1));
        end
        push("pl_drain", 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        run();
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = obs_q.pop_front();
            n_total++;
            if (o !== e) begin
                $display("FAIL %s: got rv=%b flt=%b data=%h, want rv=%b flt=%b data=%h",
                         nm, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] o;
        logic [33:0] e;
        string       nm;
        push("b2b_store", 1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        push("b2b_load",  1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        push("b2b_stb",   1'b0, 1'b1, 32'h13, 2'b00, 1'b0, 32'h1234_565A, 1'b0, 1'b0, 32'h0);
        push("b2b_ldw",   1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h5AAD_BEEF);
        push("b2b_ldh",   1'b1, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_5AAD);
        run();
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = obs_q.pop_front();
            n_total++;
            if (o !== e) begin
                $display("FAIL %s: got rv=%b flt=%b data=%h, want rv=%b flt=%b data=%h",
                         nm, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_during_load();
        int n;
        mem_read = 1'b1;
        address  = 32'h10;
        mem_size = 2'b10;
        tick();
        set_idle();
        n_total++;
        if ({rvalid, rdata} !== {1'b1, 32'h5AAD_BEEF}) begin
            $display("FAIL load_before_reset: got rv=%b data=%h, want rv=1 data=5aadbeef", rvalid, rdata);
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({rvalid, fault, rdata} !== 34'h0) begin
            $display("FAIL reset_drops_valid: got rv=%b flt=%b data=%h, want 0 0 00000000",
                     rvalid, fault, rdata);
        end else n_pass++;
        tick();
        n_total++;
        if ({ready, rvalid, rdata} !== 34'h0) begin
            $display("FAIL reset_held: got ready=%b rv=%b data=%h, want 0 0 00000000",
                     ready, rvalid, rdata);
        end else n_pass++;
        rst_n = 1'b1;
        count_to_ready(n);
        n_total++;
        if (n !== 16) begin
            $display("FAIL clear_after_load_reset: got %0d edges, want 16", n);
        end else n_pass++;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scrub();
        test_byte_half();
        test_faults();
        test_pipelined();
        test_back_to_back();
        test_reset_during_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised, byte-addressed data memory for the single-cycle/multicycle MIPS datapath. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. It scrubs its contents to zero after reset, registers read data, and flags misaligned or out-of-range accesses. It sits between the ALU address output and the write-back mux, replacing the word-only memory.

## Interface
- `ADDR_BITS`, default 10: word-index width; depth = 2^ADDR_BITS words of 32 bits.
- `CLEAR_ON_RESET`, default 1: 1 = zero all words after reset; 0 = skip scrub, go straight to RUN.
- Clk  input  1  rising-edge clock; the only clock.
- Rst_n  input  1  reset, asynchronous, active-low.
- Address  input  32  byte address.
- WriteData  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MemWrite  input  1  store request, sampled at rising Clk when Ready=1.
- MemRead  input  1  load request, sampled at rising Clk when Ready=1.
- MemSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- MemSigned  input  1  1 = sign-extend sub-word loads; 0 = zero-extend. Ignored for word accesses and stores.
- Ready  output  1  block accepts requests.
- ReadData  output  32  registered load result; 0 when ReadValid=0.
- ReadValid  output  1  one-cycle pulse; ReadData is valid.
- Fault  output  1  one-cycle pulse; the previous-cycle request was rejected.

## Operation
- **States**
  - CLEAR: Ready=0. A word counter runs 0 → 2^ADDR_BITS−1 and writes 32'h0 to one word per cycle. After the last word, go to RUN.
  - RUN: Ready=1. Requests are accepted every cycle.
  - With CLEAR_ON_RESET=0, reset goes directly to RUN.
- **Accepted request:** Ready=1 and exactly one of MemRead/MemWrite high at a rising Clk.
- **Requests ignored:** requests while Ready=0 are ignored, with no Fault and no side effect.
- **Word index and lanes:** word index = Address[ADDR_BITS+1:2]. Byte lane = Address[1:0]. Half lane = Address[1].
- **Store:** write only the addressed lanes, using byte-lane write enables. Other bytes of the word are unchanged.
  - byte: WriteData[7:0] → byte lane.
  - half: WriteData[15:0] → bytes {2·A[1]+1, 2·A[1]}.
  - word: the full word.
- **Load:** select the addressed lane(s) and extend to 32 bits per MemSigned. Little-endian: byte lane 0 = bits [7:0].
- **Fault conditions**, checked in priority order. The memory is unchanged and no ReadValid is produced.
  1. MemRead and MemWrite both high.
  2. MemSize = 11.
  3. Half access with Address[0]=1.
  4. Word access with Address[1:0]≠0.
  5. Address[31:ADDR_BITS+2] ≠ 0 (out of range).
- **Read-during-write:** back-to-back store then load to the same word returns the new data. The store commits at the edge, and the load samples at the next edge.

## Timing
- **Reset values:** Rst_n low asynchronously forces:
  - state = CLEAR (or RUN if CLEAR_ON_RESET=0), counter = 0;
  - Ready=0 (1 if no clear), ReadData=0, ReadValid=0, Fault=0.
- **Clear duration:** with clearing, Ready rises exactly 2^ADDR_BITS rising edges after Rst_n deasserts.
- **Reset mid-operation:**
  - Reset mid-CLEAR restarts the scrub from word 0.
  - Reset with a load in flight drops its ReadValid.
- **Store latency:** the memory is updated at the accepting edge.
- **Load latency 1:** a load accepted at edge N gives ReadValid=1 and ReadData valid from edge N until edge N+1. Fault has the same timing for a rejected request.
- **Throughput:** loads can be issued on consecutive cycles, giving a ReadValid train. No holding is required after acceptance.
- **Output exclusivity:** ReadValid and Fault are never high together.

## Test plan
- **Reset and scrub** (ADDR_BITS=4, CLEAR_ON_RESET=1): preload garbage, then assert Rst_n low and release it.
  - Ready stays 0 for 16 cycles, then goes to 1.
  - A word load at 0x3C returns 32'h0.
  - Assert reset at cycle 8 of the scrub: the count restarts and 16 more cycles pass before Ready=1.
- **Byte/half stores and loads:**
  - Store word 0x11223344 @0x08, byte 0xAA @0x09, half 0xBEEF @0x0A. A word load @0x08 returns 0xBEEFAA44.
  - Byte load @0x09 signed returns 0xFFFFFFAA; unsigned returns 0x000000AA.
  - Half load @0x0A signed returns 0xFFFFBEEF.
- **Faults:** each of the following gives Fault=1 for one cycle, ReadValid=0, and the word @0x00 unchanged afterwards:
  - half @0x01;
  - word @0x02;
  - MemSize=11;
  - MemRead and MemWrite together;
  - word load @0x0000_1000 with ADDR_BITS=10.
- **Pipelined reads:** loads on 4 consecutive cycles to 0x0, 0x4, 0x8, 0xC (preloaded 1, 2, 3, 4) give ReadValid high for 4 consecutive cycles with ReadData 1, 2, 3, 4.
- **Store then load:** store 0xDEADBEEF @0x10 at edge N, then load @0x10 at edge N+1. ReadData = 0xDEADBEEF after edge N+1.
- **Reset during load:** accept a load, then pull Rst_n low before the next edge. ReadValid stays 0 and ReadData stays 0.
